// File: rtl/beta_inst_decoder.sv
// Beta instruction decoder: classifies opcodes, extracts fields, keeps per-class saturating counters.
// Latency: one cycle, from accept to registered output.
// Backpressure: in_ready = !out_valid || out_ready; the output holds while stalled.
module beta_inst_decoder (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] inst,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [2:0]  out_class,
  output logic [5:0]  out_op,
  output logic [4:0]  out_ra,
  output logic [4:0]  out_rb,
  output logic [4:0]  out_rc,
  output logic [31:0] out_lit,
  output logic        out_uses_lit,
  output logic        out_writes_rc,
  input  logic [2:0]  cnt_sel,
  output logic [15:0] cnt_value,
  input  logic        cnt_clear
);

  localparam logic [2:0] C_REG     = 3'd0;
  localparam logic [2:0] C_LIT     = 3'd1;
  localparam logic [2:0] C_BRANCH  = 3'd2;
  localparam logic [2:0] C_LOAD    = 3'd3;
  localparam logic [2:0] C_STORE   = 3'd4;
  localparam logic [2:0] C_ILLEGAL = 3'd5;

  logic [5:0]  op;
  logic [2:0]  d_class;
  logic [4:0]  d_rb;
  logic [31:0] d_lit;
  logic        d_uses_lit;
  logic        d_writes_rc;
  logic        accept;

  assign op       = inst[31:26];
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Operate groups occupy 0x20-0x2F / 0x30-0x3F, each with slot 7 unused.
  always_comb begin
    d_class = C_ILLEGAL;
    if (op[5:4] == 2'b10 && op[2:0] != 3'b111) begin
      d_class = C_REG;
    end else if (op[5:4] == 2'b11 && op[2:0] != 3'b111) begin
      d_class = C_LIT;
    end else begin
      case (op)
        6'h18, 6'h1F:        d_class = C_LOAD;
        6'h19:               d_class = C_STORE;
        6'h1B, 6'h1C, 6'h1D: d_class = C_BRANCH;
        default:             d_class = C_ILLEGAL;
      endcase
    end
  end

  always_comb begin
    d_rb        = (d_class == C_REG) ? inst[15:11] : 5'd0;
    d_uses_lit  = (d_class == C_LIT) || (d_class == C_BRANCH) ||
                  (d_class == C_LOAD) || (d_class == C_STORE);
    d_writes_rc = (d_class == C_REG) || (d_class == C_LIT) ||
                  (d_class == C_BRANCH) || (d_class == C_LOAD);
    d_lit       = d_uses_lit ? {{16{inst[15]}}, inst[15:0]} : 32'd0;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      out_valid     <= 1'b0;
      out_class     <= 3'd0;
      out_op        <= 6'd0;
      out_ra        <= 5'd0;
      out_rb        <= 5'd0;
      out_rc        <= 5'd0;
      out_lit       <= 32'd0;
      out_uses_lit  <= 1'b0;
      out_writes_rc <= 1'b0;
    end else if (accept) begin
      out_valid     <= 1'b1;
      out_class     <= d_class;
      out_op        <= op;
      out_ra        <= inst[20:16];
      out_rb        <= d_rb;
      out_rc        <= inst[25:21];
      out_lit       <= d_lit;
      out_uses_lit  <= d_uses_lit;
      out_writes_rc <= d_writes_rc;
    end else if (out_ready) begin
      out_valid     <= 1'b0;
    end
  end

  // Index 6 is the total; clear acts before the same-cycle accept is counted.
  logic [15:0] cnt      [0:6];
  logic [15:0] cnt_base [0:6];
  logic        cnt_inc  [0:6];
  logic [15:0] cnt_nxt  [0:6];

  always_comb begin
    for (int i = 0; i < 7; i++) begin
      cnt_base[i] = cnt_clear ? 16'd0 : cnt[i];
      cnt_inc[i]  = accept && ((3'(i) == 3'd6) || (3'(i) == d_class)) &&
                    (cnt_base[i] != 16'hFFFF);
      cnt_nxt[i]  = cnt_base[i] + {15'd0, cnt_inc[i]};
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < 7; i++) cnt[i] <= 16'd0;
    end else begin
      for (int i = 0; i < 7; i++) cnt[i] <= cnt_nxt[i];
    end
  end

  always_comb begin
    case (cnt_sel)
      3'd0:    cnt_value = cnt[0];
      3'd1:    cnt_value = cnt[1];
      3'd2:    cnt_value = cnt[2];
      3'd3:    cnt_value = cnt[3];
      3'd4:    cnt_value = cnt[4];
      3'd5:    cnt_value = cnt[5];
      3'd6:    cnt_value = cnt[6];
      default: cnt_value = 16'd0;
    endcase
  end

endmodule

// File: tb/tb_beta_inst_decoder.sv
// Bench for beta_inst_decoder: directed literal cases plus randomized traffic against an ISA-level model.
`timescale 1ns/1ps
module tb_beta_inst_decoder;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] inst;
  logic [2:0]  out_class;
  logic [5:0]  out_op;
  logic [4:0]  out_ra, out_rb, out_rc;
  logic [31:0] out_lit;
  logic        out_uses_lit, out_writes_rc;
  logic [2:0]  cnt_sel;
  logic [15:0] cnt_value;
  logic        cnt_clear;

  always #5 CLK = ~CLK;

  beta_inst_decoder dut (
    .CLK(CLK), .RESET(RESET),
    .in_valid(in_valid), .in_ready(in_ready), .inst(inst),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_class(out_class), .out_op(out_op),
    .out_ra(out_ra), .out_rb(out_rb), .out_rc(out_rc),
    .out_lit(out_lit), .out_uses_lit(out_uses_lit), .out_writes_rc(out_writes_rc),
    .cnt_sel(cnt_sel), .cnt_value(cnt_value), .cnt_clear(cnt_clear)
  );

  typedef struct packed {
    logic [2:0]  cls;
    logic [5:0]  op;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [4:0]  rc;
    logic [31:0] lit;
    logic        uses;
    logic        writes;
  } dec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Decode straight from the opcode table of the ISA.
  function automatic dec_t ref_decode(input logic [31:0] w);
    dec_t d;
    int o = int'(w[31:26]);
    int c;
    if ((o >= 'h20 && o <= 'h26) || (o >= 'h28 && o <= 'h2E))      c = 0;
    else if ((o >= 'h30 && o <= 'h36) || (o >= 'h38 && o <= 'h3E)) c = 1;
    else if (o >= 'h1B && o <= 'h1D)                                c = 2;
    else if (o == 'h18 || o == 'h1F)                                c = 3;
    else if (o == 'h19)                                             c = 4;
    else                                                            c = 5;
    d.cls    = 3'(c);
    d.op     = w[31:26];
    d.ra     = w[20:16];
    d.rc     = w[25:21];
    d.rb     = (c == 0) ? w[15:11] : 5'd0;
    d.lit    = (c == 0 || c == 5) ? 32'd0 : {{16{w[15]}}, w[15:0]};
    d.uses   = (c >= 1 && c <= 4);
    d.writes = (c <= 3);
    return d;
  endfunction

  function automatic int sat_inc(input int v, input bit inc);
    int r = v + (inc ? 1 : 0);
    return (r > 65535) ? 65535 : r;
  endfunction

  // Model: one held result plus seven counters.
  logic m_valid;
  dec_t m_out;
  int   m_cnt [7];
  logic m_acc;
  dec_t m_in;
  bit   cmp_en = 0;

  assign m_acc = in_valid && (!m_valid || out_ready);
  always_comb m_in = ref_decode(inst);

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      m_valid <= 1'b0;
      m_out   <= '0;
      for (int i = 0; i < 7; i++) m_cnt[i] <= 0;
    end else begin
      if (m_acc) begin
        m_valid <= 1'b1;
        m_out   <= m_in;
      end else if (out_ready) begin
        m_valid <= 1'b0;
      end
      for (int i = 0; i < 7; i++)
        m_cnt[i] <= sat_inc(cnt_clear ? 0 : m_cnt[i],
                            m_acc && (i == 6 || i == int'(m_in.cls)));
    end
  end

  dec_t dut_out;
  assign dut_out = {out_class, out_op, out_ra, out_rb, out_rc, out_lit, out_uses_lit, out_writes_rc};

  always @(negedge CLK) begin
    if (!RESET && cmp_en) begin
      chk("in_ready", 64'(in_ready), 64'(!m_valid || out_ready));
      chk("out_valid", 64'(out_valid), 64'(m_valid));
      if (m_valid) chk("decoded", 64'(dut_out), 64'(m_out));
      chk("cnt_value", 64'(cnt_value), (cnt_sel == 3'd7) ? 64'd0 : 64'(m_cnt[cnt_sel]));
    end
  end

  function automatic logic [31:0] rand_inst();
    logic [31:0] w = $urandom;
    case ($urandom_range(0, 6))
      0: w[31:26] = 6'($urandom_range(0, 63));
      1: w[31:26] = 6'(($urandom_range(0, 1) ? 'h28 : 'h20) + $urandom_range(0, 6));
      2: w[31:26] = 6'(($urandom_range(0, 1) ? 'h38 : 'h30) + $urandom_range(0, 6));
      3: w[31:26] = 6'('h1B + $urandom_range(0, 2));
      4: w[31:26] = $urandom_range(0, 1) ? 6'h18 : 6'h1F;
      5: w[31:26] = 6'h19;
      default: w[31:26] = $urandom_range(0, 1) ? 6'h27 : 6'h1A;
    endcase
    return w;
  endfunction

  logic [5:0] got_ops [$];

  task automatic drive(input logic v, input logic [31:0] w, input logic r);
    in_valid  = v;
    inst      = w;
    out_ready = r;
    if (out_valid && r) got_ops.push_back(out_op);
    @(negedge CLK);
    #1;
  endtask

  initial begin
    in_valid = 0; inst = 0; out_ready = 1; cnt_sel = 0; cnt_clear = 0;
    #1 RESET = 1;
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_fields", 64'(dut_out), 64'd0);
    chk("rst_cnt", 64'(cnt_value), 64'd0);
    @(negedge CLK); #1;
    RESET = 0;
    cmp_en = 1;

    // ADD r1,r2 -> r3
    in_valid = 1; inst = 32'h80611000;
    @(negedge CLK);
    chk("add_valid", 64'(out_valid), 64'd1);
    chk("add_class", 64'(out_class), 64'd0);
    chk("add_op", 64'(out_op), 64'h20);
    chk("add_rc", 64'(out_rc), 64'd3);
    chk("add_ra", 64'(out_ra), 64'd1);
    chk("add_rb", 64'(out_rb), 64'd2);
    chk("add_lit", 64'(out_lit), 64'd0);
    chk("add_writes", 64'(out_writes_rc), 64'd1);
    chk("add_cnt0", 64'(cnt_value), 64'd1);
    #1;
    inst = 32'hC085FFFC;
    @(negedge CLK);
    chk("addc_class", 64'(out_class), 64'd1);
    chk("addc_lit", 64'(out_lit), 64'hFFFFFFFC);
    chk("addc_uses", 64'(out_uses_lit), 64'd1);
    chk("addc_rb", 64'(out_rb), 64'd0);
    #1;
    in_valid = 0; cnt_clear = 1;
    @(negedge CLK); #1;
    cnt_clear = 0; in_valid = 1; inst = 32'h9C000000;
    @(negedge CLK);
    chk("ill_class", 64'(out_class), 64'd5);
    chk("ill_writes", 64'(out_writes_rc), 64'd0);
    #1;
    inst = 32'h64000000;
    @(negedge CLK);
    chk("st_class", 64'(out_class), 64'd4);
    chk("st_uses", 64'(out_uses_lit), 64'd1);
    chk("st_writes", 64'(out_writes_rc), 64'd0);
    #1;
    in_valid = 0; cnt_sel = 5;
    #1 chk("cnt_ill", 64'(cnt_value), 64'd1);
    cnt_sel = 4;
    #1 chk("cnt_st", 64'(cnt_value), 64'd1);
    cnt_sel = 6;
    #1 chk("cnt_total2", 64'(cnt_value), 64'd2);

    // Four-instruction stream with a three-cycle stall.
    @(negedge CLK); #1;
    cnt_clear = 1;
    @(negedge CLK); #1;
    cnt_clear = 0;
    got_ops.delete();
    drive(1, 32'h80000000, 1);
    for (int k = 0; k < 3; k++) begin
      drive(1, 32'h84000000, 0);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_hold_op", 64'(out_op), 64'h20);
      chk("stall_hold_valid", 64'(out_valid), 64'd1);
    end
    drive(1, 32'h84000000, 1);
    drive(1, 32'h60000000, 1);
    drive(1, 32'h70000000, 1);
    drive(0, 32'h0, 1);
    chk("bp_count", 64'(got_ops.size()), 64'd4);
    if (got_ops.size() == 4) begin
      chk("bp_op0", 64'(got_ops[0]), 64'h20);
      chk("bp_op1", 64'(got_ops[1]), 64'h21);
      chk("bp_op2", 64'(got_ops[2]), 64'h18);
      chk("bp_op3", 64'(got_ops[3]), 64'h1C);
    end
    cnt_sel = 6;
    #1 chk("bp_total", 64'(cnt_value), 64'd4);

    repeat (3000) begin
      @(negedge CLK); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      inst      = rand_inst();
      cnt_sel   = 3'($urandom_range(0, 7));
      cnt_clear = ($urandom_range(0, 63) == 0);
    end

    // Saturation, then clear coinciding with a LOAD accept.
    @(negedge CLK); #1;
    in_valid = 1; out_ready = 1; cnt_clear = 0; inst = 32'h80611000; cnt_sel = 0;
    repeat (65540) @(negedge CLK);
    chk("sat_reg", 64'(cnt_value), 64'hFFFF);
    #1 cnt_sel = 6;
    #1 chk("sat_total", 64'(cnt_value), 64'hFFFF);
    cnt_clear = 1; inst = 32'h60000000;
    @(negedge CLK); #1;
    cnt_clear = 0; in_valid = 0; cnt_sel = 0;
    #1 chk("clr_reg", 64'(cnt_value), 64'd0);
    cnt_sel = 3;
    #1 chk("clr_load", 64'(cnt_value), 64'd1);
    cnt_sel = 6;
    #1 chk("clr_total", 64'(cnt_value), 64'd1);

    // Asynchronous reset while a result is stalled.
    @(negedge CLK); #1;
    in_valid = 1; inst = 32'h80611000; out_ready = 0;
    @(negedge CLK);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    chk("pre_rst_ready", 64'(in_ready), 64'd0);
    #1 RESET = 1;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_ready", 64'(in_ready), 64'd1);
    chk("arst_op", 64'(out_op), 64'd0);
    in_valid = 0;
    for (int s = 0; s < 7; s++) begin
      cnt_sel = 3'(s);
      #1 chk("arst_cnt", 64'(cnt_value), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/beta_inst_decoder.md
# beta_inst_decoder

Receiving end of the Beta instruction stream: accepts 32-bit Beta instructions (as produced by the random instruction generator or fetch) over a valid/ready handshake. Each instruction is decoded into class, register fields and a sign-extended literal, and presented one cycle later on a registered, back-pressurable output. Per-class saturating counters are also kept, so the bench can check the instruction mix against the generator's weights.

## Interface
- No parameters; all widths are fixed by the Beta ISA.
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- in_valid  in  1  `inst` holds a valid instruction.
- in_ready  out  1  decoder can accept this cycle.
- inst  in  32  instruction word: op[31:26], rc/dest[25:21], ra/src1[20:16], rb/src2[15:11], literal[15:0].
- out_valid  out  1  decoded result is valid.
- out_ready  in  1  downstream accepts the result.
- out_class  out  3  0 REG, 1 LIT, 2 BRANCH, 3 LOAD, 4 STORE, 5 ILLEGAL.
- out_op  out  6  opcode.
- out_ra, out_rb, out_rc  out  5 each  register fields; out_rb is forced to 0 for every class other than REG.
- out_lit  out  32  inst[15:0] sign-extended; 0 for REG and ILLEGAL.
- out_uses_lit  out  1  high for LIT, BRANCH, LOAD and STORE.
- out_writes_rc  out  1  high for REG, LIT, BRANCH and LOAD; low for STORE and ILLEGAL.
- cnt_sel  in  3  counter select: 0–5 select the class counters, 6 selects the total, 7 reads as 0.
- cnt_value  out  16  combinational read of the selected counter.
- cnt_clear  in  1  synchronous clear of all counters.

## Operation
- Classification by op:
  - REG: 0x20–0x26, 0x28–0x2E.
  - LIT: 0x30–0x36, 0x38–0x3E.
  - BRANCH: 0x1B–0x1D.
  - LOAD: 0x18, 0x1F.
  - STORE: 0x19.
  - ILLEGAL: every other opcode.
- Accept event: in_valid && in_ready. On accept, the decoded fields are registered into the output stage and out_valid is set.
- in_ready = !out_valid || out_ready. This is a single-stage pipeline register with full throughput: back-to-back accepts occur when out_ready stays high.
- out_valid clears when out_ready is high and there is no accept in the same cycle.
- While out_valid && !out_ready, all out_* signals hold stable. in_ready is low and `inst` is ignored.
- ILLEGAL instructions still flow through the output stage (out_class=5, out_lit=0, out_uses_lit=0, out_writes_rc=0); they are not dropped.
- Counters: seven 16-bit registers, one per class plus a total.
  - On accept, the class counter and the total counter each increment by 1.
  - Counters saturate at 0xFFFF; there is no wrap.
- cnt_clear zeroes all counters. If an accept happens in the same cycle, clear is applied first and then the accept is counted: the accepted class counter and the total counter end at 1, all others at 0.
- cnt_value = counter[cnt_sel]; a change on cnt_sel takes effect in the same cycle.

## Timing
- Reset values (asynchronous, take effect immediately on RESET):
  - out_valid=0, so in_ready=1.
  - out_class=0, out_op=0, out_ra=out_rb=out_rc=0, out_lit=0, out_uses_lit=0, out_writes_rc=0.
  - All counters 0, so cnt_value=0.
- Latency: an instruction accepted at edge N is on the outputs with out_valid=1 after edge N, and stays there until the first edge where out_ready=1.
- RESET asserted mid-stream discards the held result and counter state.
- First accept after RESET deasserts: the first rising edge with in_valid=1.
- Stall boundary: with out_ready low for k cycles, zero instructions are accepted during those cycles. No instruction is lost or duplicated.

## Test plan
- Reset, then inst=0x80611000 (ADD, rc=3, ra=1, rb=2) with in_valid=1 for 1 cycle:
  - Next cycle: out_valid=1, out_class=0, out_op=0x20, out_rc=3, out_ra=1, out_rb=2, out_lit=0, out_writes_rc=1.
  - cnt_sel=0 reads 1.
- inst=0xC085FFFC (ADDC, rc=4, ra=5, lit=0xFFFC): out_class=1, out_lit=0xFFFFFFFC, out_uses_lit=1, out_rb=0.
- inst=0x9C000000 (op 0x27) then inst=0x64000000 (ST):
  - First result: out_class=5, out_writes_rc=0.
  - Second result: out_class=4, out_uses_lit=1, out_writes_rc=0.
  - Counters: cnt_sel=5 reads 1, cnt_sel=4 reads 1, cnt_sel=6 reads 2.
- Backpressure: stream 4 instructions with out_ready low for cycles 2–4:
  - in_ready is low during the stall.
  - Outputs hold stable during the stall.
  - All 4 results emerge in order; total counter = 4.
- Saturation and clear:
  - 65 540 REG accepts → cnt_sel=0 reads 0xFFFF.
  - cnt_clear pulsed with a simultaneous LOAD accept → cnt_sel=0 reads 0, cnt_sel=3 reads 1, cnt_sel=6 reads 1.
- RESET asserted while out_valid=1 and out_ready=0 → out_valid=0, in_ready=1, and all counters 0, without waiting for a clock edge.
